// File: rtl/pic_control_logic.sv
// 8259 PIC control logic: ICW/OCW command decoder, INT generation and the
// two-pulse INTA sequencer that places the interrupt vector on the data bus.
module pic_control_logic (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic       a0,
  input  logic [7:0] din,
  input  logic       inta_n,
  input  logic       int_req,
  input  logic [2:0] isr_level,
  output logic       int_out,
  output logic [7:0] dout,
  output logic       dout_en,
  output logic       level_or_edge_flag,
  output logic [7:0] mask,
  output logic       aeoi,
  output logic       eoi,
  output logic       set,
  output logic [1:0] intAcounter
);

  typedef enum logic [2:0] {UNINIT, ICW2, ICW3, ICW4, READY} state_t;

  state_t     state, state_next;
  logic       wr_q, inta_q, a0_q;
  logic [7:0] din_q;
  logic       ic4, sngl;
  logic [4:0] vector_base;
  logic [7:0] vector;

  logic write_commit, icw1, ocw2, inta_fall, inta_rise, inta_read, cpu_read;

  assign write_commit = !cs_n && !wr_q && wr_n;
  assign icw1         = write_commit && !a0_q && din_q[4];
  assign ocw2         = write_commit && (state == READY) && !a0_q && (din_q[4:3] == 2'b00);
  assign inta_fall    = inta_q && !inta_n;
  assign inta_rise    = !inta_q && inta_n;
  // ICW1 aborts any INTA in progress, so it also suppresses the vector drive.
  assign inta_read    = (intAcounter == 2'b10) && !inta_n && !icw1;
  assign cpu_read     = !cs_n && !rd_n;

  // Strobe history for edge detection and write data capture while wr_n is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= 1'b1;
      inta_q <= 1'b1;
      a0_q   <= 1'b0;
      din_q  <= '0;
    end else begin
      wr_q   <= wr_n;
      inta_q <= inta_n;
      if (!wr_n) begin
        a0_q  <= a0;
        din_q <= din;
      end
    end
  end

  // Init sequence state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= UNINIT;
    else     state <= state_next;
  end

  // Init sequence next state; a0=0 writes other than ICW1 hold the state.
  always_comb begin
    state_next = state;
    if (icw1) begin
      state_next = ICW2;
    end else if (write_commit && a0_q) begin
      case (state)
        ICW2:    state_next = !sngl ? ICW3 : (ic4 ? ICW4 : READY);
        ICW3:    state_next = ic4 ? ICW4 : READY;
        ICW4:    state_next = READY;
        default: state_next = state;
      endcase
    end
  end

  // Static controls decoded from ICW1/ICW2/ICW4 and OCW1/OCW2; the cascade
  // word (ICW3) only advances the sequence since single mode never uses it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ic4                <= 1'b0;
      sngl               <= 1'b0;
      level_or_edge_flag <= 1'b0;
      mask               <= '1;
      aeoi               <= 1'b0;
      eoi                <= 1'b0;
      set                <= 1'b0;
      vector_base        <= '0;
    end else begin
      eoi <= 1'b0;
      if (icw1) begin
        ic4                <= din_q[0];
        sngl               <= din_q[1];
        level_or_edge_flag <= din_q[3];
        mask               <= '0;
        aeoi               <= 1'b0;
        set                <= 1'b0;
      end else if (write_commit && a0_q) begin
        case (state)
          ICW2:    vector_base <= din_q[7:3];
          ICW4:    aeoi        <= din_q[1];
          READY:   mask        <= din_q;
          default: ;
        endcase
      end else if (ocw2) begin
        eoi <= din_q[5];
        if (!din_q[6]) set <= din_q[7];
      end
    end
  end

  // INTA phase counter, vector latch and INT request to the CPU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      intAcounter <= 2'b00;
      vector      <= '0;
      int_out     <= 1'b0;
    end else if (icw1) begin
      intAcounter <= 2'b00;
      int_out     <= 1'b0;
    end else begin
      int_out <= (state == READY) && int_req && (intAcounter == 2'b00) && !inta_fall;
      if (state == READY) begin
        if (inta_fall && intAcounter == 2'b00) begin
          intAcounter <= 2'b01;
        end else if (inta_fall && intAcounter == 2'b01) begin
          intAcounter <= 2'b10;
          vector      <= {vector_base, isr_level};
        end else if (inta_rise && intAcounter == 2'b10) begin
          intAcounter <= 2'b00;
        end
      end
    end
  end

  // Registered bus drive: INTA vector has priority over a CPU read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout    <= '0;
      dout_en <= 1'b0;
    end else if (inta_read) begin
      dout    <= vector;
      dout_en <= 1'b1;
    end else if (cpu_read) begin
      dout    <= a0 ? mask : 8'h00;
      dout_en <= 1'b1;
    end else begin
      dout    <= '0;
      dout_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pic_control_logic.sv
// Directed bench for pic_control_logic: init sequence, OCW1/OCW2, reads,
// INTA handshake, ICW1 abort and reset during INTA.
module tb_pic_control_logic;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1, a0 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       inta_n = 1'b1, int_req = 1'b0;
  logic [2:0] isr_level = 3'd0;
  logic       int_out, dout_en, level_or_edge_flag, aeoi, eoi, set;
  logic [7:0] dout, mask;
  logic [1:0] intAcounter;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  pic_control_logic dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .a0(a0),
    .din(din), .inta_n(inta_n), .int_req(int_req), .isr_level(isr_level),
    .int_out(int_out), .dout(dout), .dout_en(dout_en),
    .level_or_edge_flag(level_or_edge_flag), .mask(mask), .aeoi(aeoi),
    .eoi(eoi), .set(set), .intAcounter(intAcounter)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns on the negedge right after the commit edge.
  task automatic bus_write(input logic addr, input logic [7:0] data);
    @(negedge clk); cs_n = 1'b0; a0 = addr; din = data; wr_n = 1'b0;
    @(negedge clk); wr_n = 1'b1;
    @(negedge clk); cs_n = 1'b1;
  endtask

  task automatic bus_read(input string tag, input logic addr, input logic [7:0] exp);
    @(negedge clk); cs_n = 1'b0; a0 = addr; rd_n = 1'b0;
    @(negedge clk);
    check({tag, "_dout"}, {8'h00, dout}, {8'h00, exp});
    check({tag, "_en"}, {15'h0, dout_en}, 16'h1);
    rd_n = 1'b1; cs_n = 1'b1;
    @(negedge clk);
    check({tag, "_en_drop"}, {15'h0, dout_en}, 16'h0);
  endtask

  task automatic inta_pulse();
    @(negedge clk); inta_n = 1'b0;
    @(negedge clk); inta_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_int", {15'h0, int_out}, 16'h0);
    check("rst_dout", {8'h0, dout}, 16'h0);
    check("rst_en", {15'h0, dout_en}, 16'h0);
    check("rst_ltim", {15'h0, level_or_edge_flag}, 16'h0);
    check("rst_mask", {8'h0, mask}, 16'h00FF);
    check("rst_aeoi", {15'h0, aeoi}, 16'h0);
    check("rst_eoi", {15'h0, eoi}, 16'h0);
    check("rst_set", {15'h0, set}, 16'h0);
    check("rst_cnt", {14'h0, intAcounter}, 16'h0);
    rst = 1'b0;

    // UNINIT: INTA and requests ignored
    int_req = 1'b1;
    inta_pulse();
    check("uninit_cnt", {14'h0, intAcounter}, 16'h0);
    check("uninit_int", {15'h0, int_out}, 16'h0);
    int_req = 1'b0;

    // Init: ICW1 0x1B, ICW2 0x40, ICW4 0x03 (ICW3 skipped)
    bus_write(1'b0, 8'h1B);
    check("icw1_ltim", {15'h0, level_or_edge_flag}, 16'h1);
    check("icw1_mask", {8'h0, mask}, 16'h0000);
    bus_write(1'b1, 8'h40);
    check("icw2_aeoi", {15'h0, aeoi}, 16'h0);
    bus_write(1'b1, 8'h03);
    check("icw4_aeoi", {15'h0, aeoi}, 16'h1);
    check("icw4_mask", {8'h0, mask}, 16'h0000);

    // OCW1 and reads
    bus_write(1'b1, 8'hA5);
    check("ocw1_mask", {8'h0, mask}, 16'h00A5);
    bus_read("rd_a1", 1'b1, 8'hA5);
    bus_read("rd_a0", 1'b0, 8'h00);

    // OCW2
    bus_write(1'b0, 8'h20);
    check("eoi_pulse", {15'h0, eoi}, 16'h1);
    check("eoi_set", {15'h0, set}, 16'h0);
    @(negedge clk);
    check("eoi_drop", {15'h0, eoi}, 16'h0);
    bus_write(1'b0, 8'h80);
    check("rot_on", {15'h0, set}, 16'h1);
    bus_write(1'b0, 8'hE0);
    check("sl_eoi", {15'h0, eoi}, 16'h1);
    check("sl_set_held", {15'h0, set}, 16'h1);
    bus_write(1'b0, 8'h00);
    check("rot_off", {15'h0, set}, 16'h0);
    check("ocw2_mask", {8'h0, mask}, 16'h00A5);

    // INT and two-pulse INTA
    int_req = 1'b1; isr_level = 3'd5;
    @(negedge clk);
    check("int_on", {15'h0, int_out}, 16'h1);
    inta_n = 1'b0;
    @(negedge clk);
    check("inta1_cnt", {14'h0, intAcounter}, 16'h1);
    check("inta1_int", {15'h0, int_out}, 16'h0);
    inta_n = 1'b1;
    @(negedge clk);
    check("inta1r_cnt", {14'h0, intAcounter}, 16'h1);
    inta_n = 1'b0;
    @(negedge clk);
    check("inta2_cnt", {14'h0, intAcounter}, 16'h2);
    @(negedge clk);
    check("vec_dout", {8'h0, dout}, 16'h0045);
    check("vec_en", {15'h0, dout_en}, 16'h1);
    inta_n = 1'b1;
    @(negedge clk);
    check("inta2r_cnt", {14'h0, intAcounter}, 16'h0);
    check("inta2r_en", {15'h0, dout_en}, 16'h0);
    check("inta2r_int", {15'h0, int_out}, 16'h0);
    @(negedge clk);
    check("int_reassert", {15'h0, int_out}, 16'h1);

    // ICW1 during INTA phase 01 aborts and restarts init
    inta_n = 1'b0;
    @(negedge clk);
    check("abort_pre_cnt", {14'h0, intAcounter}, 16'h1);
    inta_n = 1'b1;
    bus_write(1'b0, 8'h1B);
    check("abort_cnt", {14'h0, intAcounter}, 16'h0);
    check("abort_int", {15'h0, int_out}, 16'h0);
    bus_write(1'b1, 8'h40);
    check("abort_icw2_mask", {8'h0, mask}, 16'h0000);
    check("abort_icw2_int", {15'h0, int_out}, 16'h0);
    bus_write(1'b1, 8'h01);
    check("reinit_aeoi", {15'h0, aeoi}, 16'h0);
    @(negedge clk);
    check("reinit_int", {15'h0, int_out}, 16'h1);

    // Reset while the counter is 10
    inta_n = 1'b0;
    @(negedge clk); inta_n = 1'b1;
    @(negedge clk); inta_n = 1'b0;
    @(negedge clk);
    check("pre_rst_cnt", {14'h0, intAcounter}, 16'h2);
    @(negedge clk);
    check("pre_rst_en", {15'h0, dout_en}, 16'h1);
    #2 rst = 1'b1;
    #1;
    check("midrst_cnt", {14'h0, intAcounter}, 16'h0);
    check("midrst_en", {15'h0, dout_en}, 16'h0);
    check("midrst_dout", {8'h0, dout}, 16'h0);
    check("midrst_mask", {8'h0, mask}, 16'h00FF);
    check("midrst_int", {15'h0, int_out}, 16'h0);
    @(negedge clk); inta_n = 1'b1; rst = 1'b0;
    inta_pulse();
    inta_pulse();
    check("postrst_cnt", {14'h0, intAcounter}, 16'h0);
    check("postrst_int", {15'h0, int_out}, 16'h0);
    bus_write(1'b0, 8'h1B);
    bus_write(1'b1, 8'h40);
    bus_write(1'b1, 8'h03);
    @(negedge clk);
    check("postrst_reinit_int", {15'h0, int_out}, 16'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
